change_dispenser: RTL and testbench

Sequences the return-change path of the vending controller. On a start pulse it pays out a change amount one coin at a time, using a greedy largest-coin-first policy over 20/10/5 denominations. Each coin is issued to the coin-hopper mechanism through a 4-phase req/ack handshake, and the block keeps per-denomination inventory counters. It sits between the transaction FSM's RETURN_CHANGE state and the physical hopper driver.

---
 rtl/change_dispenser.sv | 232 +++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 20/10/5 change payout over a 4-phase req/ack coin hopper,
// with per-denomination inventory counters.
// Optional feature macro: CHANGE_TIMEOUT_EN (abort a coin request when the hopper
// does not acknowledge within ACK_TIMEOUT cycles; reports fault and short).
module change_dispenser #(
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             load,
    input  logic [CNT_W-1:0] load_n5,
    input  logic [CNT_W-1:0] load_n10,
    input  logic [CNT_W-1:0] load_n20,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] n5,
    output logic [CNT_W-1:0] n10,
    output logic [CNT_W-1:0] n20
);

    localparam logic [1:0] SEL_5  = 2'd0;
    localparam logic [1:0] SEL_10 = 2'd1;
    localparam logic [1:0] SEL_20 = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_REQ     = 3'd2,
        S_RELEASE = 3'd3,
        S_FINISH  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             coin_req_q, coin_req_d;
    logic [1:0]       coin_sel_q, coin_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] n5_q, n5_d;
    logic [CNT_W-1:0] n10_q, n10_d;
    logic [CNT_W-1:0] n20_q, n20_d;
    logic [AMT_W-1:0] coin_val;

`ifdef CHANGE_TIMEOUT_EN
    localparam int unsigned TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    logic            fault_q, fault_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Value of the coin currently being issued; used to debit remaining on ack.
    always_comb begin
        coin_val = AMT_W'(5);
        case (coin_sel_q)
            SEL_20:  coin_val = AMT_W'(20);
            SEL_10:  coin_val = AMT_W'(10);
            default: coin_val = AMT_W'(5);
        endcase
    end

    // Next-state and output-register logic for the payout sequencer.
    always_comb begin
        state_d     = state_q;
        coin_req_d  = coin_req_q;
        coin_sel_d  = coin_sel_q;
        done_d      = 1'b0;
        short_d     = short_q;
        remaining_d = remaining_q;
        n5_d        = n5_q;
        n10_d       = n10_q;
        n20_d       = n20_q;
`ifdef CHANGE_TIMEOUT_EN
        fault_d     = fault_q;
        to_cnt_d    = to_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    n5_d  = load_n5;
                    n10_d = load_n10;
                    n20_d = load_n20;
                end
                if (start) begin
                    remaining_d = change_amt;
                    short_d     = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
                    fault_d     = 1'b0;
`endif
                    state_d     = S_SELECT;
                end
            end

            S_SELECT: begin
                // Greedy choice; the >= compares guarantee the later debit cannot wrap.
                if (remaining_q == '0) begin
                    short_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else if ((remaining_q >= AMT_W'(20)) && (n20_q != '0)) begin
                    coin_sel_d = SEL_20;
                    coin_req_d = 1'b1;
                    state_d    = S_REQ;
                end else if ((remaining_q >= AMT_W'(10)) && (n10_q != '0)) begin
                    coin_sel_d = SEL_10;
                    coin_req_d = 1'b1;
                    state_d    = S_REQ;
                end else if ((remaining_q >= AMT_W'(5)) && (n5_q != '0)) begin
                    coin_sel_d = SEL_5;
                    coin_req_d = 1'b1;
                    state_d    = S_REQ;
                end else begin
                    short_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end
`ifdef CHANGE_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end

            S_REQ: begin
                if (coin_ack) begin
                    coin_req_d  = 1'b0;
                    remaining_d = remaining_q - coin_val;
                    case (coin_sel_q)
                        SEL_20:  n20_d = n20_q - CNT_W'(1);
                        SEL_10:  n10_d = n10_q - CNT_W'(1);
                        default: n5_d  = n5_q - CNT_W'(1);
                    endcase
                    state_d = S_RELEASE;
                end
`ifdef CHANGE_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    // Hopper never answered: abandon without touching amount or inventory.
                    coin_req_d = 1'b0;
                    short_d    = 1'b1;
                    fault_d    = 1'b1;
                    done_d     = 1'b1;
                    state_d    = S_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end

            S_RELEASE: begin
                // Complete the 4-phase handshake before another request may rise.
                if (!coin_ack) begin
                    state_d = S_SELECT;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                coin_req_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            coin_req_q  <= 1'b0;
            coin_sel_q  <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remaining_q <= '0;
            n5_q        <= '0;
            n10_q       <= '0;
            n20_q       <= '0;
        end else begin
            state_q     <= state_d;
            coin_req_q  <= coin_req_d;
            coin_sel_q  <= coin_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            remaining_q <= remaining_d;
            n5_q        <= n5_d;
            n10_q       <= n10_d;
            n20_q       <= n20_d;
        end
    end

`ifdef CHANGE_TIMEOUT_EN
    // Acknowledge timeout counter and fault flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q  <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            fault_q  <= fault_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign coin_req  = coin_req_q;
    assign coin_sel  = coin_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign short     = short_q;
    assign remaining = remaining_q;
    assign n5        = n5_q;
    assign n10       = n10_q;
    assign n20       = n20_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a behavioural hopper responder.
// Timeout scenario is compiled in only when CHANGE_TIMEOUT_EN is defined.
module tb_change_dispenser;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] change_amt;
    logic       load;
    logic [3:0] load_n5, load_n10, load_n20;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       coin_ack;
    logic       busy, done, short, fault;
    logic [7:0] remaining;
    logic [3:0] n5, n10, n20;

    int checks;
    int errors;

    // Hopper model controls and observations
    bit hopper_on;
    int ack_delay;
    int ack_hold;
    int coins[$];
    int stable_err;
    int early_req;

    change_dispenser dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .change_amt (change_amt),
        .load       (load),
        .load_n5    (load_n5),
        .load_n10   (load_n10),
        .load_n20   (load_n20),
        .coin_req   (coin_req),
        .coin_sel   (coin_sel),
        .coin_ack   (coin_ack),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .fault      (fault),
        .remaining  (remaining),
        .n5         (n5),
        .n10        (n10),
        .n20        (n20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Hopper: records each coin, acks after ack_delay cycles, holds ack ack_hold cycles.
    initial begin
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (hopper_on && coin_req === 1'b1) begin
                coins.push_back(int'(coin_sel));
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    if (coin_req !== 1'b1 || int'(coin_sel) != coins[$]) stable_err++;
                end
                coin_ack = 1'b1;
                @(negedge clk);
                for (int i = 0; i < ack_hold; i++) begin
                    if (coin_req !== 1'b0) early_req++;
                    @(negedge clk);
                end
                if (coin_req !== 1'b0) early_req++;
                coin_ack = 1'b0;
            end
        end
    end

    task automatic do_load(input logic [3:0] a5, input logic [3:0] a10, input logic [3:0] a20);
        @(posedge clk); #1;
        load = 1'b1; load_n5 = a5; load_n10 = a10; load_n20 = a20;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Start is driven just after edge k; returns just after edge k+1.
    task automatic pulse_start(input logic [7:0] amt);
        @(posedge clk); #1;
        start = 1'b1; change_amt = amt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int req_cycles;
        checks = 0; errors = 0;
        hopper_on = 1'b0; ack_delay = 0; ack_hold = 0;
        stable_err = 0; early_req = 0;
        reset_n = 1'b0; start = 1'b0; change_amt = '0;
        load = 1'b0; load_n5 = '0; load_n10 = '0; load_n20 = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_coin_req", 32'(coin_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_counts", {20'd0, n5, n10, n20}, 32'd0);
        reset_n = 1'b1;

        // 1: greedy 35 from 5/5/5 with immediate ack
        do_load(4'd5, 4'd5, 4'd5);
        @(negedge clk);
        check("t1_load_n20", 32'(n20), 32'd5);
        hopper_on = 1'b1; coins.delete();
        pulse_start(8'd35);
        @(negedge clk);
        check("t1_busy_k1", 32'(busy), 32'd1);
        check("t1_req_k1", 32'(coin_req), 32'd0);
        @(negedge clk);
        check("t1_req_k2", 32'(coin_req), 32'd1);
        wait_done(40, n);
        check("t1_done_cycle", 32'(n + 2), 32'd11);
        check("t1_ncoins", 32'(coins.size()), 32'd3);
        if (coins.size() == 3) begin
            check("t1_coin0", 32'(coins[0]), 32'd2);
            check("t1_coin1", 32'(coins[1]), 32'd1);
            check("t1_coin2", 32'(coins[2]), 32'd0);
        end
        check("t1_short", 32'(short), 32'd0);
        check("t1_fault", 32'(fault), 32'd0);
        check("t1_remaining", 32'(remaining), 32'd0);
        check("t1_counts", {20'd0, n5, n10, n20}, 32'h444);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: 40 from n5=3 n10=1 n20=0 runs short
        do_load(4'd3, 4'd1, 4'd0);
        coins.delete();
        pulse_start(8'd40);
        wait_done(60, n);
        check("t2_ncoins", 32'(coins.size()), 32'd4);
        if (coins.size() == 4) begin
            check("t2_coin0", 32'(coins[0]), 32'd1);
            check("t2_coin3", 32'(coins[3]), 32'd0);
        end
        check("t2_short", 32'(short), 32'd1);
        check("t2_remaining", 32'(remaining), 32'd15);
        check("t2_counts", {20'd0, n5, n10, n20}, 32'd0);

        // 3a: zero amount finishes without any request
        coins.delete();
        pulse_start(8'd0);
        @(negedge clk);
        check("t3_done_k1", 32'(done), 32'd0);
        @(negedge clk);
        check("t3_done_k2", 32'(done), 32'd1);
        check("t3_short", 32'(short), 32'd0);
        check("t3_noreq", 32'(coins.size()), 32'd0);

        // 3b: load and start together; 7 with two 5-coins leaves residue 2
        @(posedge clk); #1;
        load = 1'b1; load_n5 = 4'd2; load_n10 = 4'd0; load_n20 = 4'd0;
        start = 1'b1; change_amt = 8'd7;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        wait_done(40, n);
        check("t3b_ncoins", 32'(coins.size()), 32'd1);
        check("t3b_short", 32'(short), 32'd1);
        check("t3b_remaining", 32'(remaining), 32'd2);
        check("t3b_n5", 32'(n5), 32'd1);

        // 4: slow hopper, lingering ack, start/load ignored while busy
        do_load(4'd0, 4'd3, 4'd0);
        coins.delete(); ack_delay = 4; ack_hold = 3; stable_err = 0; early_req = 0;
        pulse_start(8'd20);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; change_amt = 8'd100;
        load = 1'b1; load_n5 = 4'd9; load_n10 = 4'd9; load_n20 = 4'd9;
        @(posedge clk); #1;
        start = 1'b0; load = 1'b0;
        wait_done(80, n);
        check("t4_ncoins", 32'(coins.size()), 32'd2);
        check("t4_req_stable", 32'(stable_err), 32'd0);
        check("t4_no_early_req", 32'(early_req), 32'd0);
        check("t4_remaining", 32'(remaining), 32'd0);
        check("t4_short", 32'(short), 32'd0);
        check("t4_counts", {20'd0, n5, n10, n20}, 32'h010);
        ack_delay = 0; ack_hold = 0;
        repeat (6) @(negedge clk);

        // 5: asynchronous reset during an outstanding request
        hopper_on = 1'b0;
        do_load(4'd0, 4'd0, 4'd5);
        pulse_start(8'd20);
        repeat (2) @(negedge clk);
        check("t5_req_up", 32'(coin_req), 32'd1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("t5_req_async", 32'(coin_req), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_coin_sel", 32'(coin_sel), 32'd0);
        check("t5_remaining", 32'(remaining), 32'd0);
        check("t5_n20", 32'(n20), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_stay_idle", 32'(busy), 32'd0);

`ifdef CHANGE_TIMEOUT_EN
        // 6: hopper never acks, request abandoned after ACK_TIMEOUT cycles
        do_load(4'd1, 4'd0, 4'd0);
        pulse_start(8'd5);
        req_cycles = 0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (coin_req === 1'b1) req_cycles++;
        end
        check("t6_done_seen", 32'(done), 32'd1);
        check("t6_req_cycles", 32'(req_cycles), 32'd15);
        check("t6_fault", 32'(fault), 32'd1);
        check("t6_short", 32'(short), 32'd1);
        check("t6_n5", 32'(n5), 32'd1);
        check("t6_remaining", 32'(remaining), 32'd5);
`else
        req_cycles = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
